// File: rtl/rate_generation_pkg.sv
// Shared types for the clks_alot transmit path: clock/reset bundle, rate
// counter sizing and the edge-generator state encoding.
package common_p;
  typedef struct packed {
    logic clk;
    logic rst;
  } clk_dom_s;
endpackage

package clks_alot_p;
  localparam int RATE_COUNTER_WIDTH = 16;
  localparam int MIN_RATE           = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_A = 2'd1,
    RUN_B = 2'd2
  } gen_state_e;
endpackage

// File: rtl/rate_generation_phase_counter.sv
// Phase down-counter: splits a period P into A = P>>1 and B = P-(P>>1),
// loads (length-1) on request and flags terminal count at zero.
module rate_phase_counter
  import clks_alot_p::*;
#(
  parameter int RATE_WIDTH = RATE_COUNTER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear_i,
  input  logic                  load_a_i,
  input  logic                  load_b_i,
  input  logic [RATE_WIDTH-1:0] period_i,
  output logic                  tc_o
);

  logic [RATE_WIDTH-1:0] phase_a_s;
  logic [RATE_WIDTH-1:0] phase_b_s;
  logic [RATE_WIDTH-1:0] count_r;

  // Phase lengths; an odd period gives the extra cycle to phase B.
  always_comb begin
    phase_a_s = period_i >> 1;
    phase_b_s = period_i - phase_a_s;
  end

  // Down-counter that parks at zero until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear_i) begin
      count_r <= '0;
    end else if (load_a_i) begin
      count_r <= phase_a_s - RATE_WIDTH'(1);
    end else if (load_b_i) begin
      count_r <= phase_b_s - RATE_WIDTH'(1);
    end else if (count_r != '0) begin
      count_r <= count_r - RATE_WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign tc_o = (count_r == '0);

endmodule

// File: rtl/rate_generation.sv
// Periodic edge generator: leading/trailing edges at a programmed period,
// with rate changes applied only on period boundaries.
module rate_generation
  import clks_alot_p::*;
#(
  parameter int RATE_WIDTH = RATE_COUNTER_WIDTH
) (
  input  common_p::clk_dom_s    sys_dom_i,
  input  logic                  generation_en_i,
  input  logic                  clear_state_i,
  input  logic                  idle_polarity_i,
  input  logic                  rate_we_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  output logic                  level_o,
  output logic                  primary_edge_o,
  output logic                  secondary_edge_o,
  output logic                  any_edge_o,
  output logic                  busy_o,
  output logic                  speed_change_o,
  output logic                  rate_clamped_o,
  output logic [RATE_WIDTH-1:0] active_rate_o
);

  localparam logic [RATE_WIDTH-1:0] MIN_RATE_W = RATE_WIDTH'(MIN_RATE);

  logic clk_s;
  logic rst_s;
  assign clk_s = sys_dom_i.clk;
  assign rst_s = sys_dom_i.rst;

  gen_state_e            state_r, state_next_s;
  logic [RATE_WIDTH-1:0] pending_r, active_r;
  logic [RATE_WIDTH-1:0] wr_rate_s, next_rate_s, load_period_s;
  logic                  too_low_s, start_s, to_b_s, wrap_s, load_a_s, tc_s;
  logic                  level_r, idle_pol_r, primary_r, secondary_r, any_r;
  logic                  busy_r, speed_r, clamped_r;

  // Clamp written rates; a write in a boundary cycle is bypassed straight in.
  always_comb begin
    too_low_s   = (rate_i < MIN_RATE_W);
    wr_rate_s   = too_low_s ? MIN_RATE_W : rate_i;
    next_rate_s = rate_we_i ? wr_rate_s : pending_r;
  end

  // Next-state logic and phase-transition strobes.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    to_b_s       = 1'b0;
    wrap_s       = 1'b0;
    if (clear_state_i) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (generation_en_i) begin
            state_next_s = RUN_A;
            start_s      = 1'b1;
          end else begin
            state_next_s = IDLE;
          end
        end
        RUN_A: begin
          if (tc_s) begin
            state_next_s = RUN_B;
            to_b_s       = 1'b1;
          end else begin
            state_next_s = RUN_A;
          end
        end
        RUN_B: begin
          // Stop requests are honoured only here, so a period always completes.
          if (tc_s && generation_en_i) begin
            state_next_s = RUN_A;
            wrap_s       = 1'b1;
          end else if (tc_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = RUN_B;
          end
        end
        default: state_next_s = IDLE;
      endcase
    end
    load_a_s      = start_s | wrap_s;
    load_period_s = load_a_s ? next_rate_s : active_r;
  end

  // State register.
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) state_r <= IDLE;
    else       state_r <= state_next_s;
  end

  rate_phase_counter #(.RATE_WIDTH(RATE_WIDTH)) u_phase_counter (
    .clk      (clk_s),
    .rst      (rst_s),
    .clear_i  (clear_state_i),
    .load_a_i (load_a_s),
    .load_b_i (to_b_s),
    .period_i (load_period_s),
    .tc_o     (tc_s)
  );

  // Pending/active rate registers and sticky clamp flag.
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      pending_r <= MIN_RATE_W;
      active_r  <= MIN_RATE_W;
      clamped_r <= 1'b0;
    end else if (clear_state_i) begin
      pending_r <= MIN_RATE_W;
      active_r  <= MIN_RATE_W;
      clamped_r <= 1'b0;
    end else begin
      pending_r <= next_rate_s;
      active_r  <= load_a_s ? next_rate_s : active_r;
      clamped_r <= clamped_r | (rate_we_i & too_low_s);
    end
  end

  // Registered line level, idle polarity capture and event pulses.
  always_ff @(posedge clk_s or posedge rst_s) begin
    if (rst_s) begin
      level_r     <= 1'b0;
      idle_pol_r  <= 1'b0;
      primary_r   <= 1'b0;
      secondary_r <= 1'b0;
      any_r       <= 1'b0;
      busy_r      <= 1'b0;
      speed_r     <= 1'b0;
    end else if (clear_state_i) begin
      level_r     <= idle_polarity_i;
      idle_pol_r  <= idle_polarity_i;
      primary_r   <= 1'b0;
      secondary_r <= 1'b0;
      any_r       <= 1'b0;
      busy_r      <= 1'b0;
      speed_r     <= 1'b0;
    end else begin
      primary_r   <= load_a_s;
      secondary_r <= to_b_s;
      any_r       <= load_a_s | to_b_s;
      busy_r      <= (state_next_s != IDLE);
      speed_r     <= wrap_s & (next_rate_s != active_r);
      case (state_r)
        IDLE: begin
          idle_pol_r <= idle_polarity_i;
          level_r    <= start_s ? ~idle_polarity_i : idle_polarity_i;
        end
        RUN_A: begin
          idle_pol_r <= idle_pol_r;
          level_r    <= to_b_s ? idle_pol_r : level_r;
        end
        RUN_B: begin
          idle_pol_r <= idle_pol_r;
          level_r    <= wrap_s ? ~idle_pol_r : level_r;
        end
        default: begin
          idle_pol_r <= idle_pol_r;
          level_r    <= idle_pol_r;
        end
      endcase
    end
  end

  assign level_o          = level_r;
  assign primary_edge_o   = primary_r;
  assign secondary_edge_o = secondary_r;
  assign any_edge_o       = any_r;
  assign busy_o           = busy_r;
  assign speed_change_o   = speed_r;
  assign rate_clamped_o   = clamped_r;
  assign active_rate_o    = active_r;

endmodule

// File: tb/tb_rate_generation.sv
// Directed bench for rate_generation: per-cycle edge/level traces captured
// into bit vectors (bit k = cycle k after the enable cycle) and compared.
module tb_rate_generation;
  import common_p::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  clk_dom_s    sys_dom;
  logic        gen_en = 1'b0, clear = 1'b0, idle_pol = 1'b0, rate_we = 1'b0;
  logic [15:0] rate_in = 16'd0;
  logic        level, primary, secondary, any_edge, busy, speed, clamped;
  logic [15:0] active_rate;

  logic [63:0] prim_v, sec_v, lvl_v, any_v, spd_v, busy_v;
  int          checks = 0;
  int          failures = 0;

  assign sys_dom = {clk, rst};
  always #5 clk = ~clk;

  rate_generation #(.RATE_WIDTH(16)) dut (
    .sys_dom_i        (sys_dom),
    .generation_en_i  (gen_en),
    .clear_state_i    (clear),
    .idle_polarity_i  (idle_pol),
    .rate_we_i        (rate_we),
    .rate_i           (rate_in),
    .level_o          (level),
    .primary_edge_o   (primary),
    .secondary_edge_o (secondary),
    .any_edge_o       (any_edge),
    .busy_o           (busy),
    .speed_change_o   (speed),
    .rate_clamped_o   (clamped),
    .active_rate_o    (active_rate)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] span(input int lo, input int hi);
    logic [63:0] v = 64'd0;
    for (int k = lo; k <= hi; k++) v[k] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] b(input int k);
    return 64'd1 << k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Clear to IDLE, then present cycle 0: enable plus a write of period p.
  task automatic start_test(input logic [15:0] p);
    clear = 1'b1; gen_en = 1'b0; rate_we = 1'b0;
    step();
    clear = 1'b0; gen_en = 1'b1; rate_we = 1'b1; rate_in = p;
  endtask

  // Sample cycles 1..n; optional rate write and enable drop at given cycles.
  task automatic run(input int n, input int we_cyc, input logic [15:0] we_val, input int drop_cyc);
    prim_v = 64'd0; sec_v = 64'd0; lvl_v = 64'd0;
    any_v  = 64'd0; spd_v = 64'd0; busy_v = 64'd0;
    for (int k = 1; k <= n; k++) begin
      step();
      prim_v[k] = primary;  sec_v[k]  = secondary; lvl_v[k]  = level;
      any_v[k]  = any_edge; spd_v[k]  = speed;     busy_v[k] = busy;
      rate_we = (k == we_cyc);
      if (k == we_cyc) rate_in = we_val;
      if (k == drop_cyc) gen_en = 1'b0;
    end
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b0;
    check_eq("rst_level",   {63'd0, level},   64'd0);
    check_eq("rst_busy",    {63'd0, busy},    64'd0);
    check_eq("rst_primary", {63'd0, primary}, 64'd0);
    check_eq("rst_active",  {48'd0, active_rate}, 64'd2);
    check_eq("rst_clamped", {63'd0, clamped}, 64'd0);

    // P=10 steady stream
    start_test(16'd10);
    run(22, -1, 16'd0, -1);
    check_eq("p10_primary",   prim_v, b(1) | b(11) | b(21));
    check_eq("p10_secondary", sec_v,  b(6) | b(16));
    check_eq("p10_level",     lvl_v,  span(1, 5) | span(11, 15) | span(21, 22));
    check_eq("p10_any",       any_v,  b(1) | b(11) | b(21) | b(6) | b(16));
    check_eq("p10_speed",     spd_v,  64'd0);
    check_eq("p10_busy",      busy_v, span(1, 22));
    check_eq("p10_active",    {48'd0, active_rate}, 64'd10);

    // P=7: A=3, B=4
    start_test(16'd7);
    run(12, -1, 16'd0, -1);
    check_eq("p7_primary",   prim_v, b(1) | b(8));
    check_eq("p7_secondary", sec_v,  b(4) | b(11));
    check_eq("p7_level",     lvl_v,  span(1, 3) | span(8, 10));
    check_eq("p7_active",    {48'd0, active_rate}, 64'd7);

    // P=10 then write 6 mid-period: takes effect at cycle 11
    start_test(16'd10);
    run(18, 3, 16'd6, -1);
    check_eq("chg_primary",   prim_v, b(1) | b(11) | b(17));
    check_eq("chg_secondary", sec_v,  b(6) | b(14));
    check_eq("chg_speed",     spd_v,  b(11));
    check_eq("chg_level",     lvl_v,  span(1, 5) | span(11, 13) | span(17, 18));
    check_eq("chg_active",    {48'd0, active_rate}, 64'd6);

    // Rewriting the same period gives no speed change
    start_test(16'd10);
    run(12, 3, 16'd10, -1);
    check_eq("same_speed",   spd_v,  64'd0);
    check_eq("same_primary", prim_v, b(1) | b(11));

    // Enable dropped in RUN_A: period completes, then IDLE
    start_test(16'd10);
    run(14, -1, 16'd0, 3);
    check_eq("stop_primary",   prim_v, b(1));
    check_eq("stop_secondary", sec_v,  b(6));
    check_eq("stop_busy",      busy_v, span(1, 10));
    check_eq("stop_level",     lvl_v,  span(1, 5));

    // Rate 1 clamps to 2: edges every cycle
    start_test(16'd1);
    run(6, -1, 16'd0, -1);
    check_eq("clamp_primary",   prim_v, b(1) | b(3) | b(5));
    check_eq("clamp_secondary", sec_v,  b(2) | b(4) | b(6));
    check_eq("clamp_level",     lvl_v,  b(1) | b(3) | b(5));
    check_eq("clamp_flag",      {63'd0, clamped}, 64'd1);
    check_eq("clamp_active",    {48'd0, active_rate}, 64'd2);
    clear = 1'b1; gen_en = 1'b0;
    step();
    clear = 1'b0;
    check_eq("clear_flag", {63'd0, clamped}, 64'd0);
    check_eq("clear_busy", {63'd0, busy},    64'd0);

    // Idle polarity 1, clear mid-RUN_A, restart, polarity change ignored while running
    idle_pol = 1'b1;
    start_test(16'd10);
    run(3, -1, 16'd0, -1);
    check_eq("pol_primary", prim_v, b(1));
    check_eq("pol_level",   lvl_v,  64'd0);
    clear = 1'b1; gen_en = 1'b0;
    step();
    check_eq("abort_busy",  {63'd0, busy},     64'd0);
    check_eq("abort_level", {63'd0, level},    64'd1);
    check_eq("abort_any",   {63'd0, any_edge}, 64'd0);
    clear = 1'b0; gen_en = 1'b1; rate_we = 1'b1; rate_in = 16'd10;
    step();
    rate_we = 1'b0; idle_pol = 1'b0;
    check_eq("restart_primary", {63'd0, primary}, 64'd1);
    check_eq("restart_level",   {63'd0, level},   64'd0);
    check_eq("restart_speed",   {63'd0, speed},   64'd0);
    repeat (5) step();
    check_eq("latched_pol_secondary", {63'd0, secondary}, 64'd1);
    check_eq("latched_pol_level",     {63'd0, level},     64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
